// File: rtl/frame_strobe_sequencer.sv
// Frame strobe sequencer: turns an address/data config word stream into a held
// FrameData row plus a single one-hot FrameStrobe pulse with setup/hold spacing.
module frame_strobe_sequencer #(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter logic [4:0]  ColSelect       = 5'd0,
  parameter int unsigned SetupCycles     = 1,
  parameter int unsigned HoldCycles      = 1
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic [31:0]                WordIn,
  input  logic                       WordValid,
  output logic                       WordReady,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       Busy,
  output logic                       Error
);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_SETUP, S_STROBE, S_HOLD} state_e;

  localparam logic [3:0] SetupCnt = SetupCycles[3:0];
  localparam logic [3:0] HoldCnt  = HoldCycles[3:0];
  localparam logic [MaxFramesPerCol-1:0] StrobeOne = {{(MaxFramesPerCol-1){1'b0}}, 1'b1};

  state_e                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [4:0]                 idx_q, idx_d;
  logic                       skip_q, skip_d;
  logic                       err_q, err_d;
  logic [FrameBitsPerRow-1:0] data_q, data_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;

  logic accept, marker_ok, col_ok, idx_ok;

  assign WordReady = (state_q == S_IDLE) || (state_q == S_DATA);
  assign accept    = WordValid && WordReady;
  assign marker_ok = (WordIn[31:24] == 8'hFA);
  assign col_ok    = (WordIn[23:19] == ColSelect);
  assign idx_ok    = (32'(WordIn[4:0]) < MaxFramesPerCol);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    skip_d   = skip_q;
    err_d    = err_q;
    data_d   = data_q;
    strobe_d = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!marker_ok) begin
            err_d = 1'b1;
          end else begin
            idx_d   = WordIn[4:0];
            skip_d  = !col_ok || !idx_ok;
            err_d   = err_q || !idx_ok;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          if (skip_q) begin
            state_d = S_IDLE;
          end else begin
            data_d = WordIn[FrameBitsPerRow-1:0];
            cnt_d  = SetupCnt;
            state_d = (SetupCnt == 4'd0) ? S_STROBE : S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == 4'd1) state_d = S_STROBE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_STROBE: begin
        cnt_d   = HoldCnt;
        state_d = (HoldCnt == 4'd0) ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == 4'd1) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
    // Strobe register is loaded on entry so the pulse aligns with the STROBE state.
    if (state_d == S_STROBE) strobe_d = StrobeOne << idx_q;
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      skip_q   <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      strobe_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      skip_q   <= skip_d;
      err_q    <= err_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
    end
  end

  assign FrameData   = data_q;
  assign FrameStrobe = strobe_q;
  assign Busy        = (state_q != S_IDLE);
  assign Error       = err_q;

endmodule
